// File: rtl/mcu_fetch_unit.sv
// Instruction-fetch engine: reads program bytes through a fixed-wait-state memory
// port and queues {byte, address} pairs in a small prefetch FIFO for the decoder.
module mcu_fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH      = 4,
    parameter int                WAIT_CYC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                NOP_CYCLES = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd_en,
    input  logic [7:0]                   mem_rdata,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            flush_pc,
    output logic                         ins_valid,
    output logic [7:0]                   ins_byte,
    output logic [ADDR_W-1:0]            ins_pc,
    input  logic                         ins_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         busy
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

    state_t              state_reg;
    logic [3:0]          idle_cnt_reg;
    logic [2:0]          wait_cnt_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic [7:0]          byte_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic                capture;
    logic                pop;

    // A flush in the capture cycle discards the returning byte.
    assign capture = (state_reg == WAIT) && (wait_cnt_reg == 3'd0) && !flush;
    assign pop     = (level_reg != '0) && ins_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idle_cnt_reg <= 4'(NOP_CYCLES);
            wait_cnt_reg <= '0;
            pc_reg       <= RESET_PC;
            mem_addr     <= '0;
            mem_rd_en    <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            if (flush) begin
                pc_reg <= flush_pc;
            end
            case (state_reg)
                IDLE: begin
                    // Countdown keeps running through a flush; only the PC is replaced.
                    if (idle_cnt_reg != 4'd0) begin
                        idle_cnt_reg <= idle_cnt_reg - 4'd1;
                    end
                    if (idle_cnt_reg < 4'd2) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (!flush && (level_reg < FULL_LEVEL)) begin
                        mem_addr  <= pc_reg;
                        mem_rd_en <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= 3'(WAIT_CYC - 1);
                    state_reg    <= flush ? FETCH : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state_reg <= FETCH;
                    end else if (wait_cnt_reg == 3'd0) begin
                        pc_reg    <= pc_reg + 1'b1;
                        state_reg <= FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (capture && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !capture) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            byte_mem[wr_ptr_reg] <= mem_rdata;
            pc_mem[wr_ptr_reg]   <= pc_reg;
        end
    end

    assign ins_valid  = (level_reg != '0);
    assign ins_byte   = ins_valid ? byte_mem[rd_ptr_reg] : 8'h00;
    assign ins_pc     = ins_valid ? pc_mem[rd_ptr_reg] : '0;
    assign fifo_level = level_reg;
    assign busy       = (state_reg == ISSUE) || (state_reg == WAIT);

endmodule

// File: tb/tb_mcu_fetch_unit.sv
// Bench for mcu_fetch_unit: a timeline/queue model checks the main instance every
// cycle; a second instance with three wait states is checked with directed values.
module tb_mcu_fetch_unit;
    localparam int NOP = 6;
    localparam int WC  = 1;
    localparam int DEP = 4;

    logic        clk;
    logic        reset, flush, ins_ready;
    logic [15:0] flush_pc, mem_addr, ins_pc;
    logic        mem_rd_en, ins_valid, busy;
    logic [7:0]  mem_rdata, ins_byte;
    logic [2:0]  fifo_level;

    logic        reset2, flush2, ready2, mem_rd_en2, ins_valid2, busy2;
    logic [15:0] flush_pc2, mem_addr2, ins_pc2;
    logic [7:0]  rdata2, ins_byte2;
    logic [2:0]  fifo_level2;

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    mcu_fetch_unit #(.ADDR_W(16), .DEPTH(DEP), .WAIT_CYC(WC), .RESET_PC(16'h0100),
                     .NOP_CYCLES(NOP)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .flush(flush), .flush_pc(flush_pc),
        .ins_valid(ins_valid), .ins_byte(ins_byte), .ins_pc(ins_pc),
        .ins_ready(ins_ready), .fifo_level(fifo_level), .busy(busy));

    mcu_fetch_unit #(.ADDR_W(16), .DEPTH(4), .WAIT_CYC(3), .RESET_PC(16'h0000),
                     .NOP_CYCLES(0)) u_dut3 (
        .clk(clk), .reset(reset2), .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2),
        .mem_rdata(rdata2), .flush(flush2), .flush_pc(flush_pc2),
        .ins_valid(ins_valid2), .ins_byte(ins_byte2), .ins_pc(ins_pc2),
        .ins_ready(ready2), .fifo_level(fifo_level2), .busy(busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rdata2 = 8'h00;
        forever begin
            @(posedge clk);
            #2 rdata2 = rdata2 + 8'd13;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: edge-indexed timeline. A read issued at edge k returns at edge k+1+WC;
    // the next read may go out one edge after a capture, flush, or the idle window.
    int          cyc = 0;
    int          ready_from, m_cap, m_issue;
    bit          m_out, m_on = 1'b0, m_pop;
    logic [15:0] m_pc, m_addr;
    logic [15:0] q_pc[$];
    logic [7:0]  q_byte[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q_pc.delete(); q_byte.delete();
            m_pc = 16'h0100; m_addr = 16'h0000; m_out = 1'b0; m_issue = -1;
            ready_from = cyc + NOP + 1;
            m_on = 1'b1;
        end else if (m_on) begin
            m_pop = (q_pc.size() != 0) && ins_ready;
            if (flush) begin
                q_pc.delete(); q_byte.delete();
                m_pc  = flush_pc;
                m_out = 1'b0;
                if (ready_from < cyc + 1) ready_from = cyc + 1;
            end else begin
                if (m_out && cyc == m_cap) begin
                    q_pc.push_back(m_pc);
                    q_byte.push_back(mem_fn(m_pc));
                    m_pc = m_pc + 16'd1;
                    m_out = 1'b0;
                    ready_from = cyc + 1;
                end else if (!m_out && cyc >= ready_from && q_pc.size() < DEP) begin
                    m_out = 1'b1; m_issue = cyc; m_cap = cyc + 1 + WC; m_addr = m_pc;
                end
                if (m_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_byte.pop_front());
                end
            end
        end
    end

    int rd_count = 0;
    always @(negedge clk) begin
        if (m_on && !reset) begin
            chk("mem_rd_en", 32'(mem_rd_en), 32'(m_out && m_issue == cyc));
            chk("busy", 32'(busy), 32'(m_out));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("fifo_level", 32'(fifo_level), 32'(q_pc.size()));
            chk("ins_valid", 32'(ins_valid), 32'(q_pc.size() != 0));
            chk("ins_pc", 32'(ins_pc), (q_pc.size() != 0) ? 32'(q_pc[0]) : 32'd0);
            chk("ins_byte", 32'(ins_byte), (q_pc.size() != 0) ? 32'(q_byte[0]) : 32'd0);
            if (mem_rd_en) rd_count++;
        end
    end

    logic [15:0] pop_pc[$];
    logic [7:0]  pop_byte[$];
    always @(posedge clk) begin
        if (!reset && ins_valid && ins_ready && !flush) begin
            pop_pc.push_back(ins_pc);
            pop_byte.push_back(ins_byte);
            $display("pop pc=%h byte=%h", ins_pc, ins_byte);
        end
    end

    int n, base, len;
    logic [7:0] exp2;

    initial begin
        reset = 1'b1; flush = 1'b0; flush_pc = 16'h0000; ins_ready = 1'b0;
        reset2 = 1'b1; flush2 = 1'b0; flush_pc2 = 16'h0000; ready2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset release: first read after the 7th edge, bytes stream in order.
        ins_ready = 1'b1; reset = 1'b0;
        n = 0;
        while (!mem_rd_en && n < 50) begin @(negedge clk); n++; end
        chk("first_read_cycle", 32'(n), 32'd7);
        chk("first_read_addr", 32'(mem_addr), 32'h0100);
        n = 0;
        while (pop_pc.size() < 3 && n < 100) begin @(negedge clk); n++; end
        chk("pop0_pc", 32'(pop_pc[0]), 32'h0100);
        chk("pop1_pc", 32'(pop_pc[1]), 32'h0101);
        chk("pop2_pc", 32'(pop_pc[2]), 32'h0102);
        chk("pop0_byte", 32'(pop_byte[0]), 32'hB5);

        // Back-pressure: exactly DEPTH reads, then one pop gives one read.
        @(negedge clk); reset = 1'b1; ins_ready = 1'b0;
        repeat (2) @(negedge clk);
        base = rd_count; reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("full_reads", 32'(rd_count - base), 32'd4);
        chk("full_level", 32'(fifo_level), 32'd4);
        base = rd_count; ins_ready = 1'b1;
        @(negedge clk); ins_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("refill_reads", 32'(rd_count - base), 32'd1);
        chk("refill_level", 32'(fifo_level), 32'd4);

        // Flush during WAIT with two bytes queued.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!(fifo_level == 3'd2 && busy && !mem_rd_en) && n < 60) begin @(negedge clk); n++; end
        chk("flush_setup_level", 32'(fifo_level), 32'd2);
        flush = 1'b1; flush_pc = 16'h2000;
        @(negedge clk); flush = 1'b0;
        chk("flush_valid", 32'(ins_valid), 32'd0);
        chk("flush_level", 32'(fifo_level), 32'd0);
        len = pop_pc.size(); ins_ready = 1'b1;
        n = 0;
        while (pop_pc.size() <= len && n < 40) begin @(negedge clk); n++; end
        chk("flush_next_pc", 32'(pop_pc[len]), 32'h2000);
        chk("flush_next_byte", 32'(pop_byte[len]), 32'hA7);

        // PC wrap at the top of the address space.
        flush = 1'b1; flush_pc = 16'hFFFF;
        @(negedge clk); flush = 1'b0;
        len = pop_pc.size();
        n = 0;
        while (pop_pc.size() < len + 3 && n < 60) begin @(negedge clk); n++; end
        chk("wrap_pc0", 32'(pop_pc[len]), 32'hFFFF);
        chk("wrap_pc1", 32'(pop_pc[len+1]), 32'h0000);
        chk("wrap_pc2", 32'(pop_pc[len+2]), 32'h0001);
        chk("wrap_byte0", 32'(pop_byte[len]), 32'hA5);

        // Asynchronous reset while a read is outstanding.
        n = 0;
        while (!(busy && !mem_rd_en) && n < 20) begin @(negedge clk); n++; end
        #1 reset = 1'b1;
        #1;
        chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_valid", 32'(ins_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!mem_rd_en && n < 50) begin @(negedge clk); n++; end
        chk("restart_cycle", 32'(n), 32'd7);
        chk("restart_addr", 32'(mem_addr), 32'h0100);
        repeat (10) @(negedge clk);

        // Three wait states: byte equals rdata at the 3rd edge after the issue cycle.
        reset2 = 1'b0;
        n = 0;
        while (!mem_rd_en2 && n < 20) begin @(negedge clk); n++; end
        chk("w3_issue_busy", 32'(busy2), 32'd1);
        chk("w3_issue_addr", 32'(mem_addr2), 32'h0000);
        repeat (3) @(negedge clk);
        exp2 = rdata2;
        chk("w3_not_early", 32'(ins_valid2), 32'd0);
        @(negedge clk);
        chk("w3_valid", 32'(ins_valid2), 32'd1);
        chk("w3_byte", 32'(ins_byte2), 32'(exp2));
        chk("w3_pc", 32'(ins_pc2), 32'h0000);
        chk("w3_level", 32'(fifo_level2), 32'd1);
        n = 4;
        while (!mem_rd_en2 && n < 20) begin @(negedge clk); n++; end
        chk("w3_period", 32'(n), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
